// File: rtl/bus_share_arbiter_pkg.sv
// Shared types and elaboration helpers for the bus sharing arbiter and its
// round-robin picker.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        ACKD = 2'd3
    } arb_state_e;

    // Wide enough for the largest legal hold count (255).
    localparam int CNT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int nreq, input int hold_cycles);
        return (nreq >= 2) && (nreq <= 16) && (hold_cycles >= 1) && (hold_cycles <= 255);
    endfunction

endpackage

// File: rtl/bus_share_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found by
// searching cyclically upward from ptr+1.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            // ptr < N and gi+1 <= N, so one conditional subtract wraps correctly.
            always_comb begin
                sum = {1'b0, ptr} + (IW+1)'(gi + 1);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                cand[gi] = sum[IW-1:0];
            end
            assign hit[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one registered bus among NREQ four-phase
// REQ/ACK requesters, sequencing each grant through LOAD, HOLD and ACKD.
module bus_share_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 2,
    localparam int IW         = clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] DATA,
    output logic [NREQ-1:0]       ACK,
    output logic [WIDTH-1:0]      BUS,
    output logic                  BUS_EN,
    output logic [IW-1:0]         GNT_ID,
    output logic                  BUSY
);

    generate
        if (!params_legal(NREQ, HOLD_CYCLES)) begin : g_param_error
            $error("bus_share_arbiter: NREQ must be 2..16 and HOLD_CYCLES 1..255");
        end
    endgenerate

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             bus_en_q, bus_en_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] data_slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign data_slice[gi] = DATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        ack_d    = ack_q;
        bus_d    = bus_q;
        bus_en_d = 1'b0;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = LOAD;
                    bus_d    = data_slice[pick_idx];
                    gnt_d    = pick_idx;
                    bus_en_d = 1'b1;
                end
            end
            LOAD: begin
                state_d = HOLD;
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                // An early REQ withdrawal is ignored here; ACKD absorbs it.
                if (cnt_q == '0) begin
                    state_d       = ACKD;
                    ack_d         = '0;
                    ack_d[gnt_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACKD: begin
                if (!REQ[gnt_q]) begin
                    state_d = IDLE;
                    ack_d   = '0;
                    ptr_d   = gnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= IW'(NREQ - 1);
            ack_q    <= '0;
            bus_q    <= '0;
            bus_en_q <= 1'b0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            bus_q    <= bus_d;
            bus_en_q <= bus_en_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
        end
    end

    assign ACK    = ack_q;
    assign BUS    = bus_q;
    assign BUS_EN = bus_en_q;
    assign GNT_ID = gnt_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Scoreboard bench for bus_share_arbiter: three instances cover the default
// configuration, a long hold with mid-grant reset, and a two-requester build.
module tb_bus_share_arbiter;

    localparam int HA = 2;
    localparam int HB = 5;
    localparam int HC = 1;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_b;

    logic [3:0]   req_a, ack_a;
    logic [127:0] data_a;
    logic [31:0]  bus_a;
    logic         bus_en_a, busy_a;
    logic [1:0]   gnt_a;

    logic [3:0]   req_b, ack_b;
    logic [127:0] data_b;
    logic [31:0]  bus_b;
    logic         bus_en_b, busy_b;
    logic [1:0]   gnt_b;

    logic [1:0]   req_c, ack_c;
    logic [63:0]  data_c;
    logic [31:0]  bus_c;
    logic         bus_en_c, busy_c;
    logic [0:0]   gnt_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_vec = 0;
    int n_bad = 0;

    bus_share_arbiter #(.NREQ(4), .WIDTH(32), .HOLD_CYCLES(HA)) u_dut_a (
        .CLK(clk), .RST(rst), .REQ(req_a), .DATA(data_a), .ACK(ack_a),
        .BUS(bus_a), .BUS_EN(bus_en_a), .GNT_ID(gnt_a), .BUSY(busy_a)
    );

    bus_share_arbiter #(.NREQ(4), .WIDTH(32), .HOLD_CYCLES(HB)) u_dut_b (
        .CLK(clk), .RST(rst_b), .REQ(req_b), .DATA(data_b), .ACK(ack_b),
        .BUS(bus_b), .BUS_EN(bus_en_b), .GNT_ID(gnt_b), .BUSY(busy_b)
    );

    bus_share_arbiter #(.NREQ(2), .WIDTH(32), .HOLD_CYCLES(HC)) u_dut_c (
        .CLK(clk), .RST(rst), .REQ(req_c), .DATA(data_c), .ACK(ack_c),
        .BUS(bus_c), .BUS_EN(bus_en_c), .GNT_ID(gnt_c), .BUSY(busy_c)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Monitors: pop one expected grant per BUS_EN strobe, check ACK timing.
    int cyc_a = 0, ld_a = 0, id_a = 0;
    logic [3:0] pack_a = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pack_a = '0;
        end else begin
            cyc_a++;
            if (bus_en_a) begin
                chk("A grant expected", 64'(q_a.size() != 0), 64'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("A GNT_ID", 64'(gnt_a), 64'(e.id));
                    chk("A BUS", 64'(bus_a), 64'(e.data));
                    ld_a = cyc_a;
                    id_a = e.id;
                end
            end
            if (ack_a != 4'd0 && pack_a == 4'd0) begin
                chk("A ACK bit", 64'(ack_a), 64'd1 << id_a);
                chk("A ACK latency", 64'(cyc_a - ld_a), 64'(HA + 1));
            end
            if ($countones(ack_a) > 1) chk("A ACK multi-hot", 64'(ack_a), 64'd0);
            pack_a = ack_a;
        end
    end

    int cyc_b = 0, ld_b = 0, id_b = 0;
    logic [3:0] pack_b = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            pack_b = '0;
        end else begin
            cyc_b++;
            if (bus_en_b) begin
                chk("B grant expected", 64'(q_b.size() != 0), 64'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("B GNT_ID", 64'(gnt_b), 64'(e.id));
                    chk("B BUS", 64'(bus_b), 64'(e.data));
                    ld_b = cyc_b;
                    id_b = e.id;
                end
            end
            if (ack_b != 4'd0 && pack_b == 4'd0) begin
                chk("B ACK bit", 64'(ack_b), 64'd1 << id_b);
                chk("B ACK latency", 64'(cyc_b - ld_b), 64'(HB + 1));
            end
            pack_b = ack_b;
        end
    end

    int cyc_c = 0, ld_c = 0, id_c = 0;
    logic [1:0]  pack_c = '0;
    logic [31:0] last_bus_c = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pack_c = '0;
        end else begin
            cyc_c++;
            if (bus_en_c) begin
                chk("C grant expected", 64'(q_c.size() != 0), 64'd1);
                if (q_c.size() != 0) begin
                    e = q_c.pop_front();
                    chk("C GNT_ID", 64'(gnt_c), 64'(e.id));
                    chk("C BUS", 64'(bus_c), 64'(e.data));
                    ld_c = cyc_c;
                    id_c = e.id;
                    last_bus_c = e.data;
                end
            end else if (busy_c) begin
                chk("C BUS stable", 64'(bus_c), 64'(last_bus_c));
            end
            if (ack_c != 2'd0 && pack_c == 2'd0) begin
                chk("C ACK bit", 64'(ack_c), 64'd1 << id_c);
                chk("C ACK latency", 64'(cyc_c - ld_c), 64'(HC + 1));
            end
            pack_c = ack_c;
        end
    end

    // Behavioural requesters on A: drop REQ on ACK, re-raise with data+1 while rem>0.
    task automatic run_a(input int r0, input int r1, input int r2, input int r3, input int budget);
        int rem[4];
        int cnt;
        bit done;
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < budget) begin
            @(negedge clk);
            cnt++;
            for (int i = 0; i < 4; i++) begin
                if (ack_a[i] && req_a[i]) begin
                    req_a[i] = 1'b0;
                end else if (!req_a[i] && !ack_a[i] && rem[i] > 0) begin
                    data_a[i*32 +: 32] = data_a[i*32 +: 32] + 32'd1;
                    req_a[i] = 1'b1;
                    rem[i]--;
                end
            end
            done = (req_a == 4'd0) && (ack_a == 4'd0) && !busy_a &&
                   (rem[0] + rem[1] + rem[2] + rem[3] == 0);
        end
        chk("A run finished", 64'(done), 64'd1);
    endtask

    task automatic run_b(input int budget);
        int cnt;
        bit done;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < budget) begin
            @(negedge clk);
            cnt++;
            for (int i = 0; i < 4; i++) begin
                if (ack_b[i] && req_b[i]) req_b[i] = 1'b0;
            end
            done = (req_b == 4'd0) && (ack_b == 4'd0) && !busy_b;
        end
        chk("B run finished", 64'(done), 64'd1);
    endtask

    task automatic single_c(input int idx, input logic [31:0] d);
        @(negedge clk);
        data_c[idx*32 +: 32] = d;
        req_c[idx] = 1'b1;
        q_c.push_back('{idx, d});
        @(negedge clk);
        chk("C BUS_EN after E0", 64'(bus_en_c), 64'd1);
        @(negedge clk);
        chk("C ACK low after E1", 64'(ack_c), 64'd0);
        @(negedge clk);
        chk("C ACK after E2", 64'(ack_c), 64'd1 << idx);
        req_c[idx] = 1'b0;
        @(negedge clk);
        chk("C ACK cleared", 64'(ack_c), 64'd0);
        chk("C BUSY cleared", 64'(busy_c), 64'd0);
        chk("C BUS held in IDLE", 64'(bus_c), 64'(d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        rst_b  = 1'b1;
        req_a  = 4'b1111;
        data_a = {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000};
        req_b  = '0;
        data_b = '0;
        req_c  = '0;
        data_c = '0;
        repeat (3) @(negedge clk);

        // Reset held with every request high.
        chk("rst ACK", 64'(ack_a), 64'd0);
        chk("rst BUS", 64'(bus_a), 64'd0);
        chk("rst BUS_EN", 64'(bus_en_a), 64'd0);
        chk("rst GNT_ID", 64'(gnt_a), 64'd0);
        chk("rst BUSY", 64'(busy_a), 64'd0);
        q_a.push_back('{0, 32'hA000_0000});
        q_a.push_back('{1, 32'hA111_1111});
        q_a.push_back('{2, 32'hA222_2222});
        q_a.push_back('{3, 32'hA333_3333});
        rst   = 1'b0;
        rst_b = 1'b0;
        run_a(0, 0, 0, 0, 100);

        // All four continuously requesting: order 0,1,2,3,0.
        @(negedge clk);
        data_a = {32'h3333_3333, 32'h3222_2222, 32'h3111_1111, 32'h3000_0000};
        req_a  = 4'b1111;
        q_a.push_back('{0, 32'h3000_0000});
        q_a.push_back('{1, 32'h3111_1111});
        q_a.push_back('{2, 32'h3222_2222});
        q_a.push_back('{3, 32'h3333_3333});
        q_a.push_back('{0, 32'h3000_0001});
        run_a(1, 0, 0, 0, 150);

        // Single request with directed timing.
        @(negedge clk);
        data_a[95:64] = 32'hDEAD_BEEF;
        req_a = 4'b0100;
        q_a.push_back('{2, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("single BUS after E0", 64'(bus_a), 64'hDEAD_BEEF);
        chk("single BUS_EN after E0", 64'(bus_en_a), 64'd1);
        chk("single BUSY after E0", 64'(busy_a), 64'd1);
        chk("single GNT_ID after E0", 64'(gnt_a), 64'd2);
        @(negedge clk);
        chk("single BUS_EN after E1", 64'(bus_en_a), 64'd0);
        chk("single ACK after E1", 64'(ack_a), 64'd0);
        @(negedge clk);
        chk("single ACK after E2", 64'(ack_a), 64'd0);
        @(negedge clk);
        chk("single ACK after E3", 64'(ack_a), 64'b0100);
        req_a = 4'b0000;
        @(negedge clk);
        chk("single ACK dropped", 64'(ack_a), 64'd0);
        chk("single BUSY dropped", 64'(busy_a), 64'd0);
        chk("single BUS held", 64'(bus_a), 64'hDEAD_BEEF);

        // Early withdrawal of REQ[1] during HOLD.
        @(negedge clk);
        data_a[63:32] = 32'h4444_1111;
        req_a = 4'b0010;
        q_a.push_back('{1, 32'h4444_1111});
        @(negedge clk);
        chk("early BUS_EN after E0", 64'(bus_en_a), 64'd1);
        @(negedge clk);
        req_a[1] = 1'b0;
        @(negedge clk);
        chk("early ACK after E2", 64'(ack_a), 64'd0);
        @(negedge clk);
        chk("early ACK after E3", 64'(ack_a), 64'b0010);
        @(negedge clk);
        chk("early ACK after E4", 64'(ack_a), 64'd0);
        chk("early BUSY after E4", 64'(busy_a), 64'd0);
        // PTR now 1: with 1 and 2 requesting, 2 must win first.
        @(negedge clk);
        data_a[95:64] = 32'h4444_2222;
        req_a = 4'b0110;
        q_a.push_back('{2, 32'h4444_2222});
        q_a.push_back('{1, 32'h4444_1111});
        run_a(0, 0, 0, 0, 100);

        // B: complete a grant to 1 so PTR moves off its reset value.
        @(negedge clk);
        data_b = {32'hB333_3333, 32'hB222_2222, 32'hB111_1111, 32'hB000_0000};
        req_b  = 4'b0010;
        q_b.push_back('{1, 32'hB111_1111});
        run_b(40);
        // Grant to 2, then reset during HOLD.
        @(negedge clk);
        req_b = 4'b0100;
        q_b.push_back('{2, 32'hB222_2222});
        @(negedge clk);
        chk("B BUSY after E0", 64'(busy_b), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("B rst ACK", 64'(ack_b), 64'd0);
        chk("B rst BUS", 64'(bus_b), 64'd0);
        chk("B rst BUSY", 64'(busy_b), 64'd0);
        chk("B rst GNT_ID", 64'(gnt_b), 64'd0);
        chk("B rst BUS_EN", 64'(bus_en_b), 64'd0);
        req_b = 4'b0101;
        @(negedge clk);
        rst_b = 1'b0;
        q_b.push_back('{0, 32'hB000_0000});
        q_b.push_back('{2, 32'hB222_2222});
        run_b(60);

        // C: two requesters, one hold cycle.
        single_c(0, 32'hC0C0_0001);
        single_c(1, 32'hC0C0_0002);

        @(negedge clk);
        chk("A queue drained", 64'(q_a.size()), 64'd0);
        chk("B queue drained", 64'(q_b.size()), 64'd0);
        chk("C queue drained", 64'(q_c.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
